// File: rtl/ssp_tx_ctrl.sv
// SSP transmit sequencer: pops FIFO bytes into shift_reg_tx and generates the
// serial clock, the TI-style frame-sync pulse and the per-bit shift strobes.
//
// state | meaning
// IDLE  | no frame; launches one when enabled and the FIFO has data
// FRAME | frame-sync phase, one serial-clock period with fss_o high
// SHIFT | DATA_W bit periods; shift strobes at the start of bits 1..DATA_W-1
module ssp_tx_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable,
  input  logic fifo_empty,
  output logic fifo_rd,
  output logic ld,
  output logic shift,
  output logic sclk_o,
  output logic fss_o,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_next;
  logic             start;
  logic             pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  assign start = enable && !fifo_empty;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_cnt_next = bit_cnt;
    pop          = 1'b0;
    shift        = 1'b0;
    fss_o        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        cnt_next     = '0;
        bit_cnt_next = '0;
        if (start) begin
          pop        = 1'b1;
          state_next = FRAME;
        end
      end
      FRAME: begin
        fss_o = 1'b1;
        busy  = 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_next     = '0;
          bit_cnt_next = '0;
          state_next   = SHIFT;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        // MSB is on q straight after the load, so bit 0 gets no strobe
        shift = (cnt == '0) && (bit_cnt != '0);
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (bit_cnt == BIT_LAST) begin
            done         = 1'b1;
            bit_cnt_next = '0;
            if (start) begin
              pop        = 1'b1;
              state_next = FRAME;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        cnt_next     = '0;
        bit_cnt_next = '0;
      end
    endcase
  end

  // The IDLE pop is combinational on the inputs; mask it so reset keeps it low.
  assign fifo_rd = pop && !rst_i;
  assign ld      = fifo_rd;
  assign sclk_o  = (state != IDLE) && (cnt < CNT_HALF);

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Randomized bench for ssp_tx_ctrl: a position-in-frame reference model, a
// queue-backed FIFO and a behavioural shift_reg_tx stand-in driven by ld/shift.
module tb_ssp_tx_ctrl;

  localparam int DATA_W = 8;
  localparam int H      = 2;
  localparam int P      = 2 * H;
  localparam int F      = P * (DATA_W + 1);

  logic clk_i = 1'b0;
  logic rst_i, enable, fifo_empty;
  logic fifo_rd, ld, shift, sclk_o, fss_o, busy, done;

  always #5 clk_i = ~clk_i;

  ssp_tx_ctrl #(.DATA_W(DATA_W), .CLK_DIV(H)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .ld         (ld),
    .shift      (shift),
    .sclk_o     (sclk_o),
    .fss_o      (fss_o),
    .busy       (busy),
    .done       (done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int pos   = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] sr = '0;
  logic [DATA_W-1:0] cur_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // pos = cycles since the ld of the current frame (0 = no frame)
  task automatic check_cycle();
    logic start, e_rd, e_fss, e_sclk, e_shift, e_busy, e_done;
    int off;
    start = 1'b0; e_rd = 1'b0; e_fss = 1'b0; e_sclk = 1'b0;
    e_shift = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (rst_i) begin
      pos = 0;
    end else begin
      start = enable && (fifo_q.size() > 0);
      e_rd  = start && (pos == 0 || pos == F);
      if (pos > 0) begin
        off     = (pos - 1) % P;
        e_sclk  = off < H;
        e_fss   = pos <= P;
        e_busy  = 1'b1;
        e_done  = pos == F;
        e_shift = (pos > 2 * P) && (off == 0);
      end
    end
    chk("fifo_rd", fifo_rd, e_rd);
    chk("ld", ld, e_rd);
    chk("shift", shift, e_shift);
    chk("sclk_o", sclk_o, e_sclk);
    chk("fss_o", fss_o, e_fss);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    if (!rst_i && pos > P && (pos - 1) % P == H)
      chk("q_bit", sr[DATA_W-1], cur_data[DATA_W-1-(pos-P-1)/P]);
    if (fifo_rd) rd_cnt++;
    if (done) done_cnt++;
    if (!rst_i) begin
      if (e_rd) cur_data = fifo_q[0];
      if (ld) begin
        if (fifo_q.size() > 0) sr = fifo_q.pop_front();
      end else if (shift) begin
        sr = sr << 1;
      end
      if (e_rd) pos = 1;
      else if (pos == 0 || pos == F) pos = 0;
      else pos++;
    end
  endtask

  task automatic step(input logic r, input logic en);
    @(posedge clk_i);
    #1;
    rst_i      = r;
    enable     = en;
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk_i);
    check_cycle();
  endtask

  initial begin
    logic en_r;
    int   rst_left;
    rst_i      = 1'b1;
    enable     = 1'b1;
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'hC3);
    fifo_empty = 1'b0;

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

    // Two queued bytes back to back, the first being 0x5A
    for (int i = 0; i < 2 * F + 10; i++) step(1'b0, 1'b1);
    chk("rd_pulses", rd_cnt, 2);
    chk("done_pulses", done_cnt, 2);

    // Empty FIFO stays quiet
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    en_r     = 1'b1;
    rst_left = 0;
    for (int i = 0; i < 5000; i++) begin
      logic r;
      if ($urandom_range(0, 24) == 0) en_r = ~en_r;
      if ($urandom_range(0, 44) == 0 && fifo_q.size() < 4)
        fifo_q.push_back(DATA_W'($urandom));
      r = 1'b0;
      if (rst_left > 0) begin
        rst_left--;
        r = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst_left = int'($urandom_range(0, 2));
        r = 1'b1;
      end
      step(r, en_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ssp_tx_ctrl.md
Name: ssp_tx_ctrl

Overview:
Transmit sequencer for the SSP module. It sits directly upstream of shift_reg_tx and drives that block's ld and shift inputs. It pops bytes from the TX FIFO, which is first-word-fall-through so data is valid on its output while not empty. It also generates the serial clock and the TI-style frame-sync pulse that go off-chip alongside shift_reg_tx's q.

Parameters:
DATA_W, 8, frame length in bits; must be at least 2. Must match the shift_reg_tx width.
CLK_DIV, 2, serial-clock half-period in clk_i cycles; must be at least 1. H = CLK_DIV below.

Ports:
clk_i  in  1  system clock; all logic is on its rising edge. One clock domain.
rst_i  in  1  asynchronous, active-high reset.
enable  in  1  permits new frames to start; level-sensitive.
fifo_empty  in  1  TX FIFO empty flag.
fifo_rd  out  1  one-cycle FIFO pop strobe.
ld  out  1  load strobe to shift_reg_tx; always coincident with fifo_rd.
shift  out  1  one-cycle shift strobe to shift_reg_tx.
sclk_o  out  1  serial clock (SSPCLKOUT).
fss_o  out  1  frame sync (SSPFSSOUT).
busy  out  1  high while a frame is in progress.
done  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Reset: asserting rst_i forces all outputs to 0 immediately, state to IDLE, divider count to 0 and bit count to 0. This holds even mid-frame; the partial frame is abandoned and not retried.
- States: IDLE, FRAME, SHIFT.
- Divider counter cnt runs 0..2H-1, then wraps.
  - It is held at 0 in IDLE.
  - It is cleared to 0 on entry to FRAME and on entry to SHIFT.
- sclk_o = 1 when cnt < H and state is not IDLE; otherwise 0. Data changes on sclk_o rising edges (cnt = 0); the receiver samples on falling edges.
- IDLE:
  - fss_o = 0, shift = 0, busy = 0.
  - If enable = 1 and fifo_empty = 0: assert fifo_rd = ld = 1 for this cycle, then go to FRAME.
- FRAME: lasts 2H cycles.
  - fss_o = 1, busy = 1.
  - At cnt = 2H-1: go to SHIFT with bit count = 0.
- SHIFT: DATA_W bit periods of 2H cycles each.
  - The MSB is already on q after the load, so bit 0 needs no shift.
  - shift = 1 for exactly one cycle at cnt = 0 of bit periods 1..DATA_W-1. That is DATA_W-1 shift pulses per frame.
  - The bit count increments at cnt = 2H-1.
- Last cycle of frame (bit count = DATA_W-1, cnt = 2H-1):
  - done = 1.
  - If enable = 1 and fifo_empty = 0: assert fifo_rd = ld = 1 this cycle, and go to FRAME next cycle. This is back-to-back operation: no idle gap, and sclk_o stays continuous.
  - Otherwise go to IDLE.
- Frame timing, with ld at cycle T0:
  - fss_o is high for T1..T2H.
  - Bits occupy T(2H+1)..T(2H·(DATA_W+1)).
  - done is on the final cycle of that range.
  - busy is high from T1 through the done cycle.
- enable is sampled only at frame start (IDLE, or the done cycle). Deasserting it mid-frame lets the current frame complete.
- fifo_empty is likewise ignored except at those decision points. fifo_rd is never asserted when fifo_empty = 1.
- ld and shift are never asserted in the same cycle.
- fss_o and shift are never asserted in the same cycle.

Test Plan:
- Reset: rst_i = 1 for 50 ns with fifo_empty = 0 and enable = 1 -> all outputs are 0 throughout; the first ld is 1 cycle after rst_i falls.
- Single frame (H = 2, DATA_W = 8): ld at T0 -> fss_o high for T1..T4. There are 8 sclk_o periods of 4 cycles each, and 7 shift pulses at T9, T13, …, T33. done = 1 at T36; busy = 0 from T37.
- Integration with shift_reg_tx loaded with 0x5A: q sampled on sclk_o falling edges reads 0,1,0,1,1,0,1,0.
- Back-to-back: two FIFO entries, enable = 1 -> the second ld coincides with the first done. The second frame's fss_o starts the next cycle with no sclk_o gap. Exactly 2 fifo_rd pulses occur.
- Empty or disabled:
  - fifo_empty = 1 -> no fifo_rd, ld or sclk_o activity.
  - enable dropped at T10 of a frame -> that frame completes (done at T36), then the block returns to IDLE even though the FIFO is not empty.
- Reset mid-frame: rst_i pulsed at T20 -> outputs go to 0 asynchronously (before the next clk_i edge). After release, with data pending, a fresh full frame starts with its fss_o phase.
